// File: rtl/ysyx_22041211_pkg.sv
// Shared decode constants for the NPC instruction-decode stage.
package ysyx_22041211_pkg;

  // Major opcodes (inst[6:0]).
  localparam logic [6:0] OpcodeOpImm  = 7'b0010011;
  localparam logic [6:0] OpcodeSystem = 7'b1110011;
  localparam logic [6:0] OpcodeLui    = 7'b0110111;
  localparam logic [6:0] OpcodeAuipc  = 7'b0010111;
  localparam logic [6:0] OpcodeOp     = 7'b0110011;
  localparam logic [6:0] OpcodeStore  = 7'b0100011;
  localparam logic [6:0] OpcodeJal    = 7'b1101111;
  localparam logic [6:0] OpcodeJalr   = 7'b1100111;
  localparam logic [6:0] OpcodeBranch = 7'b1100011;
  localparam logic [6:0] OpcodeLoad   = 7'b0000011;

  // The only SYSTEM encodings the core accepts.
  localparam logic [31:0] InstEcall  = 32'h0000_0073;
  localparam logic [31:0] InstEbreak = 32'h0010_0073;

  typedef enum logic [3:0] {
    ClsOpImm   = 4'd0,
    ClsSystem  = 4'd1,
    ClsLui     = 4'd2,
    ClsAuipc   = 4'd3,
    ClsOp      = 4'd4,
    ClsStore   = 4'd5,
    ClsJal     = 4'd6,
    ClsJalr    = 4'd7,
    ClsBranch  = 4'd8,
    ClsLoad    = 4'd9,
    ClsIllegal = 4'd15
  } op_class_e;

  typedef enum logic [1:0] {
    TrapNone    = 2'd0,
    TrapEbreak  = 2'd1,
    TrapEcall   = 2'd2,
    TrapIllegal = 2'd3
  } trap_cause_e;

  typedef enum logic [2:0] {
    FmtNone,
    FmtI,
    FmtS,
    FmtB,
    FmtU,
    FmtJ
  } imm_fmt_e;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StHalt
  } state_e;

  // Immediate format implied by an op class; classes without an immediate give FmtNone.
  function automatic imm_fmt_e class_to_fmt(op_class_e cls);
    imm_fmt_e fmt;
    case (cls)
      ClsOpImm, ClsJalr, ClsLoad: fmt = FmtI;
      ClsStore:                   fmt = FmtS;
      ClsBranch:                  fmt = FmtB;
      ClsLui, ClsAuipc:           fmt = FmtU;
      ClsJal:                     fmt = FmtJ;
      default:                    fmt = FmtNone;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/ysyx_22041211_idu_if.sv
// IFU->IDU->EXU handshake and decoded-bundle signals of the decode stage.
interface ysyx_22041211_idu_if #(
  parameter int unsigned DATA_LEN   = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_LEN-1:0]   inst;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_LEN-1:0]   imm;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic [REG_ADDR_W-1:0] rd;
  logic [3:0]            op_class;
  logic [2:0]            funct3;
  logic                  funct7_5;
  logic                  rd_we;
  logic                  halt;
  logic [1:0]            trap_cause;
  logic [CNT_W-1:0]      dec_cnt;

  // Surrounding pipeline / harness side.
  modport master (
    output in_valid, inst, out_ready,
    input  in_ready, out_valid, imm, rs1, rs2, rd, op_class, funct3, funct7_5, rd_we,
    input  halt, trap_cause, dec_cnt
  );

  // Decode stage side.
  modport slave (
    input  in_valid, inst, out_ready,
    output in_ready, out_valid, imm, rs1, rs2, rd, op_class, funct3, funct7_5, rd_we,
    output halt, trap_cause, dec_cnt
  );

endinterface

// File: rtl/ysyx_22041211_imm_gen.sv
// Combinational RV32 immediate generator: instruction + format -> sign-extended immediate.
module ysyx_22041211_imm_gen
  import ysyx_22041211_pkg::*;
(
  input  logic [31:0] inst,
  input  imm_fmt_e    fmt,
  output logic [31:0] imm
);

  // Reassemble the scattered immediate bits for each base format.
  always_comb begin
    imm = '0;
    case (fmt)
      FmtI:    imm = {{20{inst[31]}}, inst[31:20]};
      FmtS:    imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FmtB:    imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FmtU:    imm = {inst[31:12], 12'b0};
      FmtJ:    imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_22041211_idu.sv
// Pipelined instruction-decode stage: combinational decode, one output register,
// trap detection with drain-then-halt, and a handed-out bundle counter.
module ysyx_22041211_idu
  import ysyx_22041211_pkg::*;
#(
  parameter int unsigned DATA_LEN   = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
) (
  input logic                clk,
  input logic                rst_n,
  ysyx_22041211_idu_if.slave bus
);

  // Raw instruction fields.
  logic [6:0] opcode;
  logic [4:0] rs1_f;
  logic [4:0] rs2_f;
  logic [4:0] rd_f;

  // Decode results.
  op_class_e             cls;
  trap_cause_e           dec_trap;
  imm_fmt_e              dec_fmt;
  logic                  use_rs1;
  logic                  use_rs2;
  logic                  wr_rd;
  logic                  rv32e_bad;
  logic [31:0]           dec_imm;
  logic [REG_ADDR_W-1:0] dec_rs1;
  logic [REG_ADDR_W-1:0] dec_rs2;
  logic [REG_ADDR_W-1:0] dec_rd;
  logic                  dec_we;

  // Control and state.
  state_e                state_q, state_d;
  trap_cause_e           trap_q, trap_d;
  logic                  out_valid_q, out_valid_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  in_ready;
  logic                  accept;
  logic                  out_fire;

  // Output bundle register.
  logic [DATA_LEN-1:0]   imm_q;
  logic [REG_ADDR_W-1:0] rs1_q;
  logic [REG_ADDR_W-1:0] rs2_q;
  logic [REG_ADDR_W-1:0] rd_q;
  op_class_e             op_class_q;
  logic [2:0]            funct3_q;
  logic                  funct7_5_q;
  logic                  rd_we_q;

  // Classify the instruction and work out which register fields it uses.
  always_comb begin
    opcode  = bus.inst[6:0];
    rs1_f   = bus.inst[19:15];
    rs2_f   = bus.inst[24:20];
    rd_f    = bus.inst[11:7];
    cls     = ClsIllegal;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    wr_rd   = 1'b0;
    if (bus.inst[1:0] == 2'b11) begin
      case (opcode)
        OpcodeOpImm:  begin cls = ClsOpImm;  use_rs1 = 1'b1; wr_rd = 1'b1; end
        OpcodeLui:    begin cls = ClsLui;    wr_rd = 1'b1; end
        OpcodeAuipc:  begin cls = ClsAuipc;  wr_rd = 1'b1; end
        OpcodeOp:     begin cls = ClsOp;     use_rs1 = 1'b1; use_rs2 = 1'b1; wr_rd = 1'b1; end
        OpcodeStore:  begin cls = ClsStore;  use_rs1 = 1'b1; use_rs2 = 1'b1; end
        OpcodeJal:    begin cls = ClsJal;    wr_rd = 1'b1; end
        OpcodeJalr:   begin cls = ClsJalr;   use_rs1 = 1'b1; wr_rd = 1'b1; end
        OpcodeBranch: begin cls = ClsBranch; use_rs1 = 1'b1; use_rs2 = 1'b1; end
        OpcodeLoad:   begin cls = ClsLoad;   use_rs1 = 1'b1; wr_rd = 1'b1; end
        OpcodeSystem: begin
          if (bus.inst == InstEcall || bus.inst == InstEbreak) cls = ClsSystem;
        end
        default:      cls = ClsIllegal;
      endcase
    end

    // RV32E has only x0..x15: any used field reaching x16+ is illegal.
    rv32e_bad = (REG_ADDR_W == 4) &&
                ((use_rs1 && rs1_f[4]) || (use_rs2 && rs2_f[4]) || (wr_rd && rd_f[4]));
    if (rv32e_bad) cls = ClsIllegal;
    if (cls == ClsIllegal) begin
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      wr_rd   = 1'b0;
    end

    // Only the exact ecall/ebreak words survive as SYSTEM; inst[20] tells them apart.
    dec_trap = TrapNone;
    if (cls == ClsIllegal) begin
      dec_trap = TrapIllegal;
    end else if (cls == ClsSystem) begin
      dec_trap = bus.inst[20] ? TrapEbreak : TrapEcall;
    end

    dec_fmt = class_to_fmt(cls);
    dec_rs1 = use_rs1 ? rs1_f[REG_ADDR_W-1:0] : '0;
    dec_rs2 = use_rs2 ? rs2_f[REG_ADDR_W-1:0] : '0;
    dec_rd  = wr_rd ? rd_f[REG_ADDR_W-1:0] : '0;
    dec_we  = wr_rd && (dec_rd != '0);
  end

  ysyx_22041211_imm_gen u_imm_gen (
    .inst (bus.inst),
    .fmt  (dec_fmt),
    .imm  (dec_imm)
  );

  assign in_ready = (state_q == StRun) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign out_fire = out_valid_q && bus.out_ready;

  // Next-state: trap acceptance enters DRAIN, the trapping bundle leaving enters HALT.
  always_comb begin
    state_d     = state_q;
    trap_d      = trap_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    case (state_q)
      StRun: begin
        if (accept && dec_trap != TrapNone) begin
          state_d = StDrain;
          trap_d  = dec_trap;
        end
      end
      StDrain: begin
        if (out_fire) state_d = StHalt;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StRun;
    endcase
    // A new accept refills the register even when the old bundle leaves the same cycle.
    if (accept) begin
      out_valid_d = 1'b1;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
    if (out_fire) cnt_d = cnt_q + CNT_W'(1);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      trap_q      <= TrapNone;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      trap_q      <= trap_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  // Bundle register: loads only on input handshake, so it holds under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      op_class_q <= ClsOpImm;
      funct3_q   <= '0;
      funct7_5_q <= 1'b0;
      rd_we_q    <= 1'b0;
    end else if (accept) begin
      imm_q      <= dec_imm;
      rs1_q      <= dec_rs1;
      rs2_q      <= dec_rs2;
      rd_q       <= dec_rd;
      op_class_q <= cls;
      funct3_q   <= bus.inst[14:12];
      funct7_5_q <= bus.inst[30];
      rd_we_q    <= dec_we;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.imm        = imm_q;
  assign bus.rs1        = rs1_q;
  assign bus.rs2        = rs2_q;
  assign bus.rd         = rd_q;
  assign bus.op_class   = op_class_q;
  assign bus.funct3     = funct3_q;
  assign bus.funct7_5   = funct7_5_q;
  assign bus.rd_we      = rd_we_q;
  assign bus.halt       = (state_q == StHalt);
  assign bus.trap_cause = trap_q;
  assign bus.dec_cnt    = cnt_q;

endmodule

// File: doc/ysyx_22041211_idu.md
# ysyx_22041211_idu

Parametrised, pipelined instruction-decode stage for the NPC core. It sits between IFU and EXU with valid/ready handshakes on both sides. It decodes all RV32I/RV32E base formats (R/I/S/B/U/J) into register indices, a sign-extended immediate, an op class and write-enable flags, registering the result in one output stage. It detects ebreak, ecall and illegal encodings, drains the trapping instruction downstream, then halts in a sticky state and keeps a decoded-instruction counter for the simulation harness.

## Interface
- `DATA_LEN`, 32: instruction/immediate width; fixed at 32 for RV32.
- `REG_ADDR_W`, 5: register index width; 5 = RV32I, 4 = RV32E.
- `CNT_W`, 32: width of the decoded-instruction counter.
- `clk`  in  1  the single clock of the block.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  IFU presents `inst`.
- `in_ready`  out  1  IDU accepts this cycle.
- `inst`  in  DATA_LEN  fetched instruction.
- `out_valid`  out  1  decoded bundle valid.
- `out_ready`  in  1  EXU accepts the bundle.
- `imm`  out  DATA_LEN  sign-extended immediate.
- `rs1`, `rs2`, `rd`  out  REG_ADDR_W each  register indices; 0 when the field is unused.
- `op_class`  out  4  decoded class, encoded as in Operation.
- `funct3`  out  3  `inst[14:12]`.
- `funct7_5`  out  1  `inst[30]`, the sub/sra select.
- `rd_we`  out  1  instruction writes `rd`; forced 0 when `rd == 0`.
- `halt`  out  1  block is in HALT.
- `trap_cause`  out  2  0 none, 1 ebreak, 2 ecall, 3 illegal; sticky once set.
- `dec_cnt`  out  CNT_W  bundles handed to EXU.

## Operation
- Decode is combinational on `inst`; results are captured into the output register when `in_valid && in_ready`.
- `op_class` encoding:
  - 0 OP_IMM (0010011)
  - 1 SYSTEM (1110011)
  - 2 LUI (0110111)
  - 3 AUIPC (0010111)
  - 4 OP (0110011)
  - 5 STORE (0100011)
  - 6 JAL (1101111)
  - 7 JALR (1100111)
  - 8 BRANCH (1100011)
  - 9 LOAD (0000011)
  - 15 ILLEGAL
- Immediate by format:
  - I (OP_IMM, JALR, LOAD): `{{20{i31}}, i[31:20]}`.
  - S: `{{20{i31}}, i[31:25], i[11:7]}`.
  - B: `{{19{i31}}, i31, i7, i[30:25], i[11:8], 1'b0}`.
  - U: `{i[31:12], 12'b0}`.
  - J: `{{11{i31}}, i31, i[19:12], i20, i[30:21], 1'b0}`.
  - Any other class: 0.
- Register fields:
  - `rs1` is used by all classes except LUI, AUIPC, JAL and SYSTEM.
  - `rs2` is used by OP, STORE and BRANCH.
  - `rd_we` is set for OP_IMM, LUI, AUIPC, OP, JAL, JALR and LOAD.
- An instruction is ILLEGAL (class 15, imm 0, `rd_we` 0) when any of these holds:
  - unknown opcode, or `inst[1:0] != 2'b11`;
  - SYSTEM other than exactly 0x00000073 (ecall) or 0x00100073 (ebreak);
  - `REG_ADDR_W == 4` and bit 4 of any used register field is set.
- State machine:
  - RUN: normal operation. Accepting ebreak, ecall or illegal sets `trap_cause` and moves to DRAIN.
  - DRAIN: `in_ready` = 0. When the trapping bundle handshakes out, move to HALT.
  - HALT: `in_ready` = 0, `out_valid` = 0, `halt` = 1. Exit only by reset.
- `dec_cnt` increments on every output handshake, including the trapping one, and wraps modulo 2^CNT_W.

## Timing
- Reset values: `out_valid` 0, every bundle field 0, `halt` 0, `trap_cause` 0, `dec_cnt` 0, state RUN.
- Latency is 1 cycle from input handshake to `out_valid`. Throughput is 1 instruction per cycle.
- `in_ready = (state == RUN) && (!out_valid || out_ready)`: combinational; it depends on `out_ready`, not on `in_valid`.
- `out_valid` and all bundle fields hold stable while `out_valid && !out_ready`.
- Simultaneous output handshake and input acceptance: the register is overwritten and `out_valid` stays 1.
- Output handshake with no new input: `out_valid` falls next cycle.
- Trap accepted in cycle N: `out_valid` in N+1. Handshake out in cycle M gives `halt` = 1 from M+1.
- Reset asserted mid-DRAIN or in HALT discards the pending bundle immediately (asynchronous).

## Structure
- Shared package `ysyx_22041211_pkg` holds:
  - opcode constants;
  - `op_class` values;
  - `trap_cause` values;
  - ecall/ebreak encodings.
- Sub-module `ysyx_22041211_imm_gen`: purely combinational `inst` + format → `imm`, reusable by a future branch predictor.
- The state machine, output register and counter live in the top module.

## Test plan
- 0x00500093 (addi x1,x0,5) → next cycle `op_class` 0, `imm` 0x00000005, `rs1` 0, `rd` 1, `rd_we` 1, `dec_cnt` 1 after handshake.
- 0xFE20AE23 (sw x2,-4(x1)) → `op_class` 5, `imm` 0xFFFFFFFC, `rs1` 1, `rs2` 2, `rd_we` 0.
- 0xFF9FF06F (jal x0,-8) → `imm` 0xFFFFFFF8, `rd_we` 0. 0x00000863 (beq x0,x0,16) → `op_class` 8, `imm` 0x00000010.
- Hold `out_ready` = 0 for 3 cycles with `in_valid` = 1 → `in_ready` 0 and the bundle stable. Then back-to-back transfers at 1 per cycle with no loss or duplication.
- 0x00100073 (ebreak) with `out_ready` = 0 for 2 cycles → `in_ready` 0 during DRAIN, `trap_cause` 1, `halt` 1 the cycle after the handshake. Assert `rst_n` in HALT → all outputs return to reset values.
- `REG_ADDR_W` = 4: 0x01000093 (addi x1,x0,16) decodes OP_IMM; 0x00500813 (addi x16,x0,5) → ILLEGAL, `trap_cause` 3, halt after drain. A 0xFFFFFFFF input is ILLEGAL in both configurations.
